// File: rtl/pipe_pkg.sv
// Shared types and EX/MEM field layout for the flow-controlled pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 102;

    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 4;

    localparam int DATA_WREG_LSB    = 0;
    localparam int DATA_RDATA2_LSB  = 5;
    localparam int DATA_ALU_RES_LSB = 37;
    localparam int DATA_ZERO_BIT    = 69;
    localparam int DATA_PC_BR_LSB   = 70;

    function automatic logic [EX_MEM_CTRL_W-1:0] pack_ex_mem_ctrl(
        input logic reg_dst, input logic reg_write, input logic branch,
        input logic mem_read, input logic mem_write);
        logic [EX_MEM_CTRL_W-1:0] c;
        c                = '0;
        c[CTRL_REGDST]   = reg_dst;
        c[CTRL_REGWRITE] = reg_write;
        c[CTRL_BRANCH]   = branch;
        c[CTRL_MEMREAD]  = mem_read;
        c[CTRL_MEMWRITE] = mem_write;
        return c;
    endfunction

    function automatic logic [EX_MEM_DATA_W-1:0] pack_ex_mem_data(
        input logic [31:0] pc_br, input logic zero, input logic [31:0] alu_res,
        input logic [31:0] rdata2, input logic [4:0] wreg);
        logic [EX_MEM_DATA_W-1:0] d;
        d                             = '0;
        d[DATA_WREG_LSB    +: 5]      = wreg;
        d[DATA_RDATA2_LSB  +: 32]     = rdata2;
        d[DATA_ALU_RES_LSB +: 32]     = alu_res;
        d[DATA_ZERO_BIT]              = zero;
        d[DATA_PC_BR_LSB   +: 32]     = pc_br;
        return d;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register; load captures in one cycle, kill (wins over load)
// invalidates and clears ctrl while data is held. No flow control of its own.
module pipe_slot #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 102
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_vld,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              vld_q,  vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (kill) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (load) begin
            vld_d  = 1'b1;
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_vld  = vld_q;
    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, 1-cycle latency, optional skid slot; with SKID=1 in_ready
// is registered (drops once two entries are held), with SKID=0 it follows out_ready combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic              accept, consume;
    logic              main_load, main_kill, main_from_skid;
    logic              skid_load, skid_kill;
    logic              main_vld, skid_vld;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;

    assign out_valid = main_vld;
    assign in_ready  = SKID ? (state_q != ST_SKID) : (!main_vld || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = main_vld && out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_kill      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_kill      = 1'b0;
        if (flush) begin
            // Redirect: anything held or offered this cycle is dropped.
            state_d   = ST_EMPTY;
            main_kill = 1'b1;
            skid_kill = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept && SKID) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end else if (consume) begin
                        main_kill = 1'b1;
                        state_d   = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_kill      = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .kill   (main_kill),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_vld  (main_vld),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    if (SKID) begin : g_skid
        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (skid_load),
            .kill   (skid_kill),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .q_vld  (skid_vld),
            .q_ctrl (skid_ctrl),
            .q_data (skid_data)
        );
    end else begin : g_no_skid
        logic unused_skid_ctl;
        assign unused_skid_ctl = skid_load | skid_kill;
        assign skid_vld  = 1'b0;
        assign skid_ctrl = '0;
        assign skid_data = '0;
    end

    // Empty stage must look like a bubble: no stray RegWrite/MemWrite downstream.
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 instance (directed + random) and SKID=0 instance.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = EX_MEM_CTRL_W;
    localparam int DW = EX_MEM_DATA_W;
    typedef logic [CW+DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    logic          flush0, in0_valid, in0_ready, out0_valid, out0_ready;
    logic [CW-1:0] in0_ctrl, out0_ctrl;
    logic [DW-1:0] in0_data, out0_data;
    logic [1:0]    occupancy0;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   bub_err = 0;
    ent_t q[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0),
        .in_valid(in0_valid), .in_ready(in0_ready), .in_ctrl(in0_ctrl), .in_data(in0_data),
        .out_valid(out0_valid), .out_ready(out0_ready), .out_ctrl(out0_ctrl), .out_data(out0_data),
        .occupancy(occupancy0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Monitors: input-side accepts feed the queue, output-side consumes are checked against it.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (!out_valid && out_ctrl != '0) bub_err++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: got unexpected entry %0h", {out_ctrl, out_data});
                end else begin
                    chk("sb_entry", {out_ctrl, out_data}, q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
        end
    end

    always @(negedge clk) begin
        if (!rst_n || flush0) begin
            q0.delete();
        end else begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb0_underflow: got unexpected entry %0h", {out0_ctrl, out0_data});
                end else begin
                    chk("sb0_entry", {out0_ctrl, out0_data}, q0.pop_front());
                end
            end
            if (in0_valid && in0_ready) q0.push_back({in0_ctrl, in0_data});
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"},  in_ready,  1'b1);
        chk({tag, "_out_ctrl"},  out_ctrl,  '0);
        chk({tag, "_out_data"},  out_data,  '0);
        chk({tag, "_occupancy"}, occupancy, 2'd0);
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        step();
    endtask

    initial begin
        logic [DW-1:0] a_d, b_d;
        logic [CW-1:0] a_c;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        flush0 = 1'b0; in0_valid = 1'b0; out0_ready = 1'b0; in0_ctrl = '0; in0_data = '0;
        a_c = pack_ex_mem_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        a_d = pack_ex_mem_data(32'h0000_1000, 1'b1, 32'h0000_00AA, 32'h0000_00BB, 5'd3);
        b_d = pack_ex_mem_data(32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31);

        #2;
        chk_reset_state("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Pass-through at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(5'h1F, DW'(i));
            chk("pt_out_valid", out_valid, 1'b1);
            chk("pt_out_data", out_data, DW'(i));
        end
        in_valid = 1'b0;
        step();
        chk("pt_drained", out_valid, 1'b0);

        // Backpressure: A and B held, C refused.
        out_ready = 1'b0;
        push(a_c, a_d);
        push(5'h02, b_d);
        push(5'h08, DW'(102'hC));
        chk("bp_occupancy", occupancy, 2'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", out_data, a_d);
        chk("bp_head_ctrl", out_ctrl, a_c);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_in_ready_back", in_ready, 1'b1);
        chk("bp_occ_after_a", occupancy, 2'd1);
        chk("bp_second", out_data, b_d);
        step();
        chk("bp_drained", out_valid, 1'b0);

        // Flush with two held and a simultaneous push.
        out_ready = 1'b0;
        push(5'h01, DW'(102'hD));
        push(5'h01, DW'(102'hE));
        chk("fl_occ_before", occupancy, 2'd2);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 5'h04; in_data = DW'(102'hF);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_out_ctrl", out_ctrl, '0);
        chk("fl_occupancy", occupancy, 2'd0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step(); step();
        chk("fl_no_ghost", out_valid, 1'b0);

        // Flush with one held while in_ready is high: offered entry still discarded.
        out_ready = 1'b0;
        push(5'h02, DW'(102'h6));
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 5'h04; in_data = DW'(102'h7);
        chk("fl1_in_ready", in_ready, 1'b1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_occupancy", occupancy, 2'd0);
        out_ready = 1'b1;
        step();
        chk("fl1_no_ghost", out_valid, 1'b0);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        push(5'h1F, DW'(102'h11));
        push(5'h1F, DW'(102'h12));
        in_valid = 1'b0;
        chk("mr_occ_before", occupancy, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("mr");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SKID=0: in_ready follows out_ready combinationally while full.
        out0_ready = 1'b1;
        in0_valid = 1'b1; in0_ctrl = 5'h03; in0_data = DW'(102'h21);
        step();
        chk("s0_valid", out0_valid, 1'b1);
        chk("s0_occ", occupancy0, 2'd1);
        out0_ready = 1'b0;
        in0_data   = DW'(102'h22);
        #1;
        chk("s0_rdy_low", in0_ready, 1'b0);
        step();
        chk("s0_hold", out0_data, DW'(102'h21));
        out0_ready = 1'b1;
        #1;
        chk("s0_rdy_high", in0_ready, 1'b1);
        step();
        chk("s0_next", out0_data, DW'(102'h22));
        in0_valid = 1'b0;
        step();
        chk("s0_drained", out0_valid, 1'b0);

        // Random valid/ready/flush traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_ctrl   = CW'($urandom_range(0, 31));
            in_data   = rnd_data();
            out_ready = ($urandom_range(0, 99) < ((i < 5000) ? 50 : 90));
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("rnd_queue_empty", q.size(), 0);
        chk("rnd_out_valid", out_valid, 1'b0);
        chk("rnd_bubble_ctrl", bub_err, 0);
        chk("s0_queue_empty", q0.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
